// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and helpers for the register-file write-back arbiter.
// Requester indices are fixed: ALU, MEM, DBG.
package regfile_wb_arbiter_pkg;

  localparam int NREQ   = 3;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 4;

  typedef logic [1:0] reqIdx_t;

  localparam reqIdx_t REQ_ALU = 2'd0;
  localparam reqIdx_t REQ_MEM = 2'd1;
  localparam reqIdx_t REQ_DBG = 2'd2;

  localparam logic [3:0] REG0     = 4'd0;
  localparam logic [7:0] DROP_MAX = 8'd255;

  // Successor in the fixed 0 -> 1 -> 2 -> 0 ring.
  function automatic reqIdx_t nextIdx(input reqIdx_t idx);
    case (idx)
      REQ_ALU: nextIdx = REQ_MEM;
      REQ_MEM: nextIdx = REQ_DBG;
      default: nextIdx = REQ_ALU;
    endcase
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational 3-way round-robin pick: scan from Ptr, wrapping 2 -> 0,
// and grant the first pending entry.
module rr_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] Pending,
  input  reqIdx_t         Ptr,
  output logic [NREQ-1:0] Grant,
  output reqIdx_t         GrantIdx,
  output logic            GrantValid
);

  reqIdx_t cand [NREQ];

  // An out-of-range pointer is treated as 0 so the scan always covers every entry.
  assign cand[0] = (Ptr > REQ_DBG) ? REQ_ALU : Ptr;

  generate
    for (genvar gi = 1; gi < NREQ; gi++) begin : gCand
      assign cand[gi] = nextIdx(cand[gi-1]);
    end
  endgenerate

  always_comb begin
    Grant      = '0;
    GrantIdx   = REQ_ALU;
    GrantValid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!GrantValid && Pending[cand[k]]) begin
        GrantValid = 1'b1;
        GrantIdx   = cand[k];
      end
    end
    if (GrantValid) Grant[GrantIdx] = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between ALU, MEM and DBG
// through one-entry buffers, round-robin issue and per-register ordering.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NREQ-1:0]    ReqValid,
  input  logic [NREQ*AW-1:0] ReqReg,
  input  logic [NREQ*DW-1:0] ReqData,
  output logic [NREQ-1:0]    ReqReady,
  input  logic [AW-1:0]    Rs,
  input  logic [AW-1:0]    Rt,
  output logic             RsBusy,
  output logic             RtBusy,
  output logic             RegWre,
  output logic [AW-1:0]    WriteReg,
  output logic [DW-1:0]    WriteData,
  output logic [7:0]       DropCount
);

  logic [NREQ-1:0] pendingReg;
  logic [AW-1:0]   pRegReg  [NREQ];
  logic [DW-1:0]   pDataReg [NREQ];
  reqIdx_t         ptrReg;

  logic [AW-1:0]   reqRegVec  [NREQ];
  logic [DW-1:0]   reqDataVec [NREQ];

  logic [NREQ-1:0] grant;
  reqIdx_t         grantIdx;
  logic            grantValid;

  logic [NREQ-1:0] conflict;
  logic [NREQ-1:0] sameCycle;
  logic [NREQ-1:0] accept;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : gUnpack
      assign reqRegVec[gi]  = ReqReg[gi*AW +: AW];
      assign reqDataVec[gi] = ReqData[gi*DW +: DW];
    end
  endgenerate

  rr_arbiter uArb (
    .Pending    (pendingReg),
    .Ptr        (ptrReg),
    .Grant      (grant),
    .GrantIdx   (grantIdx),
    .GrantValid (grantValid)
  );

  // A buffered write that is not leaving this cycle blocks new writes to its
  // register; among simultaneous requests the lower index wins, so at most one
  // write per register is ever held and acceptance order equals issue order.
  always_comb begin
    conflict  = '0;
    sameCycle = '0;
    ReqReady  = '0;
    accept    = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (j != i && pendingReg[j] && !grant[j] && pRegReg[j] == reqRegVec[i])
          conflict[i] = 1'b1;
      end
      for (int k = 0; k < i; k++) begin
        if (accept[k] && reqRegVec[k] == reqRegVec[i])
          sameCycle[i] = 1'b1;
      end
      ReqReady[i] = !Rst && (!pendingReg[i] || grant[i]) && !conflict[i] && !sameCycle[i];
      accept[i]   = ReqValid[i] && ReqReady[i];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pendingReg <= '0;
      ptrReg     <= REQ_ALU;
      RegWre     <= 1'b0;
      WriteReg   <= '0;
      WriteData  <= '0;
      DropCount  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        pRegReg[i]  <= '0;
        pDataReg[i] <= '0;
      end
    end else begin
      RegWre <= 1'b0;
      if (grantValid) begin
        pendingReg[grantIdx] <= 1'b0;
        ptrReg               <= nextIdx(grantIdx);
        WriteReg             <= pRegReg[grantIdx];
        WriteData            <= pDataReg[grantIdx];
        // r0 is hard-wired: swallow the write and count it instead.
        if (pRegReg[grantIdx] != AW'(REG0))
          RegWre <= 1'b1;
        else if (DropCount != DROP_MAX)
          DropCount <= DropCount + 8'd1;
      end
      // A refill overrides the clear above when the granted buffer is reloaded.
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          pendingReg[i] <= 1'b1;
          pRegReg[i]    <= reqRegVec[i];
          pDataReg[i]   <= reqDataVec[i];
        end
      end
    end
  end

  logic rsHit;
  logic rtHit;

  always_comb begin
    rsHit = RegWre && WriteReg == Rs;
    rtHit = RegWre && WriteReg == Rt;
    for (int j = 0; j < NREQ; j++) begin
      if (pendingReg[j] && pRegReg[j] == Rs) rsHit = 1'b1;
      if (pendingReg[j] && pRegReg[j] == Rt) rtHit = 1'b1;
    end
  end

  assign RsBusy = (Rs != AW'(REG0)) && rsHit;
  assign RtBusy = (Rt != AW'(REG0)) && rtHit;

endmodule
